// File: rtl/ysyx_23060075_wbu_pkg.sv
// ysyx_23060075_wbu_pkg: shared widths, load funct3 encodings and WBU state type
package ysyx_23060075_wbu_pkg;
   localparam int DEF_ISA_WIDTH      = 32;
   localparam int DEF_REG_ADDR_WIDTH = 5;
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   typedef enum logic {IDLE = 1'b0, WAIT_LOAD = 1'b1} wbu_state_e;
endpackage

// File: rtl/ysyx_23060075_wbu_load_ext.sv
// ysyx_23060075_load_ext: load byte/half/word extraction with legality and alignment flags
module ysyx_23060075_load_ext
   import ysyx_23060075_wbu_pkg::*;
#(
   parameter int W = DEF_ISA_WIDTH
) (
   input  logic [2:0]   funct3,
   input  logic [1:0]   off,
   input  logic [W-1:0] word,
   output logic [W-1:0] data,
   output logic         illegal,
   output logic         misaligned
);
   logic [W-1:0] sh;
   assign sh = word >> {off, 3'b000};
   // LW only ever reaches extraction with offset 0, so the shifted word is the word itself
   assign data = funct3 == F3_LB  ? {{(W-8){sh[7]}}, sh[7:0]} :
                 funct3 == F3_LH  ? {{(W-16){sh[15]}}, sh[15:0]} :
                 funct3 == F3_LBU ? {{(W-8){1'b0}}, sh[7:0]} :
                 funct3 == F3_LHU ? {{(W-16){1'b0}}, sh[15:0]} : sh;
   assign illegal = !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
   assign misaligned = ((funct3 == F3_LH || funct3 == F3_LHU) && off == 2'd3) ||
                       (funct3 == F3_LW && off != 2'd0);
endmodule

// File: rtl/ysyx_23060075_wbu.sv
// ysyx_23060075_wbu: write-back unit driving the GPR write port, one registered write per retire
module ysyx_23060075_wbu
   import ysyx_23060075_wbu_pkg::*;
#(
   parameter int ISA_WIDTH      = DEF_ISA_WIDTH,
   parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      exu_valid,
   output logic                      exu_ready,
   input  logic [REG_ADDR_WIDTH-1:0] exu_rd,
   input  logic                      exu_wen,
   input  logic [ISA_WIDTH-1:0]      exu_data,
   input  logic                      exu_is_load,
   input  logic [2:0]                exu_funct3,
   input  logic                      lsu_rvalid,
   input  logic [ISA_WIDTH-1:0]      lsu_rdata,
   output logic [ISA_WIDTH-1:0]      gpr_w,
   output logic [REG_ADDR_WIDTH-1:0] gpr_w_addr,
   output logic                      gpr_w_en,
   output logic                      wb_done,
   output logic                      pend_valid,
   output logic [REG_ADDR_WIDTH-1:0] pend_rd,
   output logic                      err
);
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
   wbu_state_e                state;
   logic [REG_ADDR_WIDTH-1:0] l_rd;
   logic                      l_wen;
   logic [2:0]                l_f3;
   logic [1:0]                l_off;
   logic [7:0]                cnt;
   logic [ISA_WIDTH-1:0]      ext_data;
   logic                      illegal;
   logic                      misaligned;
   logic                      in_wait;
   logic                      wait_pend;
   logic [2:0]                sel_f3;
   logic [1:0]                sel_off;
   assign in_wait   = state == WAIT_LOAD;
   assign exu_ready = state == IDLE;
   assign wait_pend = in_wait & l_wen & (l_rd != '0);
   assign pend_valid = gpr_w_en | wait_pend;
   assign pend_rd   = gpr_w_en ? gpr_w_addr : wait_pend ? l_rd : '0;
   // one extractor: checks the incoming request in IDLE, extracts the latched one in WAIT_LOAD
   assign sel_f3  = in_wait ? l_f3 : exu_funct3;
   assign sel_off = in_wait ? l_off : exu_data[1:0];
   ysyx_23060075_load_ext #(.W(ISA_WIDTH)) u_load_ext (
      .funct3     (sel_f3),
      .off        (sel_off),
      .word       (lsu_rdata),
      .data       (ext_data),
      .illegal    (illegal),
      .misaligned (misaligned)
   );
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         l_rd       <= '0;
         l_wen      <= 1'b0;
         l_f3       <= '0;
         l_off      <= '0;
         cnt        <= '0;
         gpr_w      <= '0;
         gpr_w_addr <= '0;
         gpr_w_en   <= 1'b0;
         wb_done    <= 1'b0;
         err        <= 1'b0;
      end else begin
         gpr_w_en <= 1'b0;
         wb_done  <= 1'b0;
         if (state == IDLE) begin
            if (exu_valid && !exu_is_load) begin
               gpr_w_en   <= exu_wen && exu_rd != '0;
               gpr_w_addr <= exu_rd;
               gpr_w      <= exu_data;
               wb_done    <= 1'b1;
            end else if (exu_valid) begin
               l_rd  <= exu_rd;
               l_wen <= exu_wen;
               l_f3  <= exu_funct3;
               l_off <= exu_data[1:0];
               cnt   <= '0;
               if (illegal || misaligned) begin
                  err     <= 1'b1;
                  wb_done <= 1'b1;
               end else begin
                  state <= WAIT_LOAD;
               end
            end
         end else if (lsu_rvalid) begin
            gpr_w_en   <= l_wen && l_rd != '0;
            gpr_w_addr <= l_rd;
            gpr_w      <= ext_data;
            wb_done    <= 1'b1;
            state      <= IDLE;
         end else if (cnt == CNT_LAST) begin
            err     <= 1'b1;
            wb_done <= 1'b1;
            state   <= IDLE;
         end else begin
            cnt <= cnt + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_ysyx_23060075_wbu.sv
// tb_ysyx_23060075_wbu: directed and randomized transaction checks against a behavioural model
module tb_ysyx_23060075_wbu;
   localparam int TMO = 8;
   logic        clk = 1'b0;
   logic        rst;
   logic        exu_valid;
   logic        exu_ready;
   logic [4:0]  exu_rd;
   logic        exu_wen;
   logic [31:0] exu_data;
   logic        exu_is_load;
   logic [2:0]  exu_funct3;
   logic        lsu_rvalid;
   logic [31:0] lsu_rdata;
   logic [31:0] gpr_w;
   logic [4:0]  gpr_w_addr;
   logic        gpr_w_en;
   logic        wb_done;
   logic        pend_valid;
   logic [4:0]  pend_rd;
   logic        err;
   int          n_chk = 0;
   int          n_pass = 0;
   logic        exp_err = 1'b0;

   ysyx_23060075_wbu #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk         (clk),
      .rst         (rst),
      .exu_valid   (exu_valid),
      .exu_ready   (exu_ready),
      .exu_rd      (exu_rd),
      .exu_wen     (exu_wen),
      .exu_data    (exu_data),
      .exu_is_load (exu_is_load),
      .exu_funct3  (exu_funct3),
      .lsu_rvalid  (lsu_rvalid),
      .lsu_rdata   (lsu_rdata),
      .gpr_w       (gpr_w),
      .gpr_w_addr  (gpr_w_addr),
      .gpr_w_en    (gpr_w_en),
      .wb_done     (wb_done),
      .pend_valid  (pend_valid),
      .pend_rd     (pend_rd),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ext_model(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
      logic [7:0]  b = 8'(w >> (8 * off));
      logic [15:0] h = 16'(w >> (8 * off));
      case (f3)
         3'd0:    return 32'($signed(b));
         3'd1:    return 32'($signed(h));
         3'd4:    return 32'(b);
         3'd5:    return 32'(h);
         default: return w;
      endcase
   endfunction

   task automatic alu(input logic [4:0] rd, input logic wen, input logic [31:0] data);
      logic en = wen && rd != 5'd0;
      exu_valid = 1'b1; exu_is_load = 1'b0; exu_rd = rd; exu_wen = wen; exu_data = data;
      exu_funct3 = 3'($urandom_range(0, 7));
      chk("alu_rdy", exu_ready, 1);
      step();
      exu_valid = 1'b0;
      chk("alu_wen", gpr_w_en, en);
      chk("alu_done", wb_done, 1);
      chk("alu_pend", pend_valid, en);
      chk("alu_err", err, exp_err);
      if (en) begin
         chk("alu_addr", gpr_w_addr, rd);
         chk("alu_data", gpr_w, data);
         chk("alu_prd", pend_rd, rd);
      end
   endtask

   task automatic load(input logic [4:0] rd, input logic wen, input logic [2:0] f3,
                       input logic [1:0] off, input logic [31:0] rdata, input int delay);
      logic [31:0] a = $urandom();
      logic bad = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ||
                  ((f3 == 3'd1 || f3 == 3'd5) && off == 2'd3) || (f3 == 3'd2 && off != 2'd0);
      logic pend = wen && rd != 5'd0;
      exu_valid = 1'b1; exu_is_load = 1'b1; exu_rd = rd; exu_wen = wen; exu_funct3 = f3;
      exu_data = {a[31:2], off};
      chk("ld_rdy", exu_ready, 1);
      step();
      exu_valid = 1'b0;
      if (bad) begin
         exp_err = 1'b1;
         chk("bad_done", wb_done, 1);
         chk("bad_wen", gpr_w_en, 0);
         chk("bad_err", err, 1);
         chk("bad_rdy", exu_ready, 1);
         return;
      end
      for (int i = 1; i <= TMO && i <= delay; i++) begin
         chk("wait_rdy", exu_ready, 0);
         chk("wait_done", wb_done, 0);
         chk("wait_pend", pend_valid, pend);
         if (pend) chk("wait_prd", pend_rd, rd);
         lsu_rvalid = (i == delay);
         lsu_rdata = (i == delay) ? rdata : $urandom();
         step();
      end
      lsu_rvalid = 1'b0;
      chk("ld_done", wb_done, 1);
      chk("ld_rdy_after", exu_ready, 1);
      if (delay <= TMO) begin
         chk("ld_wen", gpr_w_en, pend);
         chk("ld_err", err, exp_err);
         if (pend) begin
            chk("ld_data", gpr_w, ext_model(f3, off, rdata));
            chk("ld_addr", gpr_w_addr, rd);
            chk("ld_prd", pend_rd, rd);
         end
      end else begin
         exp_err = 1'b1;
         chk("tmo_wen", gpr_w_en, 0);
         chk("tmo_err", err, 1);
      end
   endtask

   task automatic gap(input int n);
      exu_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         lsu_rvalid = 1'($urandom_range(0, 1));
         lsu_rdata = $urandom();
         step();
         chk("gap_done", wb_done, 0);
         chk("gap_wen", gpr_w_en, 0);
         chk("gap_pend", pend_valid, 0);
         chk("gap_rdy", exu_ready, 1);
      end
      lsu_rvalid = 1'b0;
   endtask

   initial begin
      rst = 1'b0; exu_valid = 1'b0; exu_rd = '0; exu_wen = 1'b0; exu_data = '0;
      exu_is_load = 1'b0; exu_funct3 = '0; lsu_rvalid = 1'b0; lsu_rdata = '0;
      step(); step();
      chk("rst_rdy", exu_ready, 1);
      chk("rst_gpr_w", gpr_w, 0);
      chk("rst_addr", gpr_w_addr, 0);
      chk("rst_wen", gpr_w_en, 0);
      chk("rst_done", wb_done, 0);
      chk("rst_err", err, 0);
      chk("rst_pend", pend_valid, 0);
      chk("rst_prd", pend_rd, 0);
      @(negedge clk) rst = 1'b1;
      step();
      alu(5'd5, 1'b1, 32'h1234_5678);
      alu(5'd0, 1'b1, 32'hFFFF_FFFF);
      gap(1);
      load(5'd9, 1'b1, 3'd0, 2'd3, 32'h80AA_BBCC, 4);
      load(5'd10, 1'b1, 3'd5, 2'd2, 32'h8001_0000, 2);
      load(5'd11, 1'b1, 3'd1, 2'd2, 32'h8001_0000, 1);
      load(5'd12, 1'b1, 3'd2, 2'd0, 32'hDEAD_BEEF, TMO);
      chk("edge_resp_no_err", err, 0);
      load(5'd13, 1'b1, 3'd2, 2'd0, 32'hDEAD_BEEF, TMO + 1);
      load(5'd14, 1'b1, 3'd2, 2'd1, 32'h0, 1);
      alu(5'd3, 1'b1, 32'hCAFE_F00D);
      // reset while a load is outstanding
      exu_valid = 1'b1; exu_is_load = 1'b1; exu_rd = 5'd7; exu_wen = 1'b1;
      exu_funct3 = 3'd2; exu_data = '0;
      step();
      exu_valid = 1'b0;
      step();
      chk("mid_pend", pend_valid, 1);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_rdy", exu_ready, 1);
      chk("mid_rst_pend", pend_valid, 0);
      chk("mid_rst_err", err, 0);
      chk("mid_rst_wen", gpr_w_en, 0);
      exp_err = 1'b0;
      @(negedge clk) rst = 1'b1;
      lsu_rvalid = 1'b1; lsu_rdata = 32'h1111_2222;
      step();
      lsu_rvalid = 1'b0;
      chk("post_rst_wen", gpr_w_en, 0);
      chk("post_rst_done", wb_done, 0);
      for (int k = 0; k < 250; k++) begin
         if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 3));
         if ($urandom_range(0, 1) == 1)
            alu(5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0), $urandom());
         else
            load(5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)), $urandom(), $urandom_range(1, TMO + 2));
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
